// File: rtl/tlul_pkg.sv
// TL-UL bus types and opcodes shared by all crossbar devices.
package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;

    localparam logic [2:0] AccessAck     = 3'h0;
    localparam logic [2:0] AccessAckData = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [3:0]  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_sram_ctrl_pkg.sv
// Response record and request legality check for the TL-UL SRAM controller.
package tlul_sram_ctrl_pkg;
    import tlul_pkg::*;

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] size;
        logic [7:0] source;
        logic       error;
        logic       is_read;
    } rsp_t;

    // Queue entry: response metadata plus the data word captured with it.
    typedef struct packed {
        rsp_t        rsp;
        logic [31:0] data;
    } rsp_ent_t;

    function automatic logic req_is_err(input logic [2:0]  opcode,
                                        input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input logic [31:0] limit,
                                        input logic        err_wr,
                                        input logic        err_rd);
        logic is_get;
        logic is_put;
        is_get = (opcode == Get);
        is_put = (opcode == PutFullData) || (opcode == PutPartialData);
        return (!is_get && !is_put) || (size > 2'd2) || (addr >= limit) ||
               (err_wr && is_put) || (err_rd && is_get);
    endfunction

endpackage

// File: rtl/tlul_rsp_fifo.sv
// Fall-through response FIFO; head is visible combinationally whenever not empty.
module tlul_rsp_fifo #(
    parameter type         T     = logic,
    parameter int unsigned Depth = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         i_push,
    input  T                             i_data,
    input  logic                         i_pop,
    output T                             o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(Depth+1)-1:0]   o_count
);
    localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CW = $clog2(Depth + 1);

    T               r_mem [Depth];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic           w_push;
    logic           w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(Depth));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_pop   = i_pop && !o_empty;
    // A push into a full FIFO is allowed when the head leaves in the same cycle.
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PW'(Depth - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PW'(Depth - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tlul_sram_ctrl.sv
// TL-UL device in front of a byte-maskable single-port SRAM with error
// responses and a bounded-outstanding in-order response path.
module tlul_sram_ctrl
    import tlul_pkg::*;
    import tlul_sram_ctrl_pkg::*;
#(
    parameter int unsigned Depth       = 4096,
    parameter int unsigned Outstanding = 4,
    parameter bit          ErrOnWrite  = 1'b0,
    parameter bit          ErrOnRead   = 1'b0
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  tl_h2d_t tl_i,
    output tl_d2h_t tl_o
);
    localparam int unsigned AW    = $clog2(Depth);
    localparam int unsigned QD    = Outstanding - 1;
    localparam int unsigned CW    = $clog2(QD + 1);
    localparam int unsigned IW    = $clog2(Outstanding + 1);
    localparam logic [31:0] Limit = 32'(Depth * 4);

    logic [31:0]   r_mem [Depth];
    logic [31:0]   r_rdata;
    logic          r_s_valid;
    rsp_t          r_s_rsp;

    logic [AW-1:0] w_idx;
    logic [IW-1:0] w_inflight;
    logic [CW-1:0] w_q_count;
    logic          w_a_ready;
    logic          w_accept;
    logic          w_err;
    logic          w_is_get;
    logic          w_q_empty;
    logic          w_q_full;
    logic          w_q_push;
    logic          w_q_pop;
    logic          w_d_valid;
    logic          w_d_hs;
    logic          w_s_direct;
    logic          w_s_done;
    rsp_ent_t      w_s_ent;
    rsp_ent_t      w_q_head;
    rsp_ent_t      w_d_ent;
    logic          w_unused;

    assign w_unused   = ^{tl_i.a_param, tl_i.a_address[1:0]};
    assign w_idx      = tl_i.a_address[AW+1:2];
    assign w_inflight = IW'(r_s_valid) + IW'(w_q_count);
    assign w_a_ready  = !rst_i && (w_inflight < IW'(Outstanding));
    assign w_accept   = tl_i.a_valid && w_a_ready;
    assign w_is_get   = (tl_i.a_opcode == Get);
    assign w_err      = req_is_err(tl_i.a_opcode, tl_i.a_size, tl_i.a_address,
                                   Limit, ErrOnWrite, ErrOnRead);

    always_ff @(posedge clk_i) begin
        if (w_accept && !w_err) begin
            if (w_is_get) begin
                r_rdata <= r_mem[w_idx];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (tl_i.a_mask[b]) begin
                        r_mem[w_idx][8*b +: 8] <= tl_i.a_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // S drives D directly only while the queue is empty; otherwise it drains into the queue.
    assign w_s_ent.rsp  = r_s_rsp;
    assign w_s_ent.data = r_s_rsp.is_read ? r_rdata : 32'h0;
    assign w_s_direct   = r_s_valid && w_q_empty;
    assign w_d_valid    = r_s_valid || !w_q_empty;
    assign w_d_ent      = w_s_direct ? w_s_ent : w_q_head;
    assign w_d_hs       = w_d_valid && tl_i.d_ready;
    assign w_q_pop      = w_d_hs && !w_q_empty;
    assign w_q_push     = r_s_valid && !(w_s_direct && w_d_hs) && (!w_q_full || w_q_pop);
    assign w_s_done     = (w_s_direct && w_d_hs) || w_q_push;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s_valid <= 1'b0;
            r_s_rsp   <= '0;
        end else if (w_accept) begin
            r_s_valid       <= 1'b1;
            r_s_rsp.opcode  <= w_is_get ? AccessAckData : AccessAck;
            r_s_rsp.size    <= tl_i.a_size;
            r_s_rsp.source  <= tl_i.a_source;
            r_s_rsp.error   <= w_err;
            r_s_rsp.is_read <= w_is_get && !w_err;
        end else if (w_s_done) begin
            r_s_valid <= 1'b0;
        end
    end

    tlul_rsp_fifo #(
        .T     (rsp_ent_t),
        .Depth (QD)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_q_push),
        .i_data  (w_s_ent),
        .i_pop   (w_q_pop),
        .o_data  (w_q_head),
        .o_full  (w_q_full),
        .o_empty (w_q_empty),
        .o_count (w_q_count)
    );

    always_comb begin
        tl_o         = '0;
        tl_o.a_ready = w_a_ready;
        if (w_d_valid) begin
            tl_o.d_valid  = 1'b1;
            tl_o.d_opcode = w_d_ent.rsp.opcode;
            tl_o.d_size   = w_d_ent.rsp.size;
            tl_o.d_source = w_d_ent.rsp.source;
            tl_o.d_data   = w_d_ent.data;
            tl_o.d_error  = w_d_ent.rsp.error;
        end
    end

endmodule

// File: tb/tb_tlul_sram_ctrl.sv
// Directed bench for tlul_sram_ctrl: a Depth=16 instance plus an ErrOnWrite instance.
module tb_tlul_sram_ctrl;
    import tlul_pkg::*;

    logic    clk;
    logic    rst;
    tl_h2d_t h2d [2];
    tl_d2h_t d2h [2];
    tl_d2h_t rq [$];
    int      n_checks;
    int      n_errors;

    tlul_sram_ctrl #(.Depth(16), .Outstanding(4)) dut (
        .clk_i (clk), .rst_i (rst), .tl_i (h2d[0]), .tl_o (d2h[0])
    );

    tlul_sram_ctrl #(.Depth(16), .Outstanding(4), .ErrOnWrite(1'b1)) dut_ew (
        .clk_i (clk), .rst_i (rst), .tl_i (h2d[1]), .tl_o (d2h[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        #1;
        for (int s = 0; s < 2; s++) begin
            if (!rst && d2h[s].d_valid && h2d[s].d_ready) rq.push_back(d2h[s]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input int s, input logic [2:0] op, input logic [31:0] addr,
                        input logic [1:0] size, input logic [3:0] mask,
                        input logic [31:0] data, input logic [7:0] src);
        int t;
        t = 0;
        h2d[s].a_valid   = 1'b1;
        h2d[s].a_opcode  = op;
        h2d[s].a_size    = size;
        h2d[s].a_address = addr;
        h2d[s].a_mask    = mask;
        h2d[s].a_data    = data;
        h2d[s].a_source  = src;
        #1;
        while (!d2h[s].a_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("send_accept", 32'(d2h[s].a_ready), 32'd1);
        @(negedge clk);
        h2d[s].a_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [2:0] op, input logic err,
                           input logic [31:0] data, input logic [7:0] src,
                           input logic [1:0] sz);
        int t;
        tl_d2h_t r;
        t = 0;
        #2;
        while (rq.size() == 0 && t < 50) begin
            @(negedge clk);
            #2;
            t++;
        end
        chk({tag, "_present"}, 32'(rq.size() > 0), 32'd1);
        if (rq.size() > 0) begin
            r = rq.pop_front();
            chk({tag, "_opcode"}, 32'(r.d_opcode), 32'(op));
            chk({tag, "_error"},  32'(r.d_error),  32'(err));
            chk({tag, "_data"},   r.d_data,        data);
            chk({tag, "_source"}, 32'(r.d_source), 32'(src));
            chk({tag, "_size"},   32'(r.d_size),   32'(sz));
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        h2d[0] = '0;
        h2d[1] = '0;
        h2d[0].d_ready = 1'b1;
        h2d[1].d_ready = 1'b1;
        dut_ew.r_mem[0] = 32'h5A5A_1234;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_a_ready", 32'(d2h[0].a_ready), 32'd0);
        chk("rst_d_valid", 32'(d2h[0].d_valid), 32'd0);
        chk("rst_d_fields", 32'(d2h[0].d_data) | 32'(d2h[0].d_source), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_a_ready", 32'(d2h[0].a_ready), 32'd1);
        @(negedge clk);

        // Full write then read
        send(0, PutFullData, 32'h10, 2'd2, 4'hF, 32'hDEAD_BEEF, 8'd1);
        get_rsp("wr_full", AccessAck, 1'b0, 32'h0, 8'd1, 2'd2);
        send(0, Get, 32'h10, 2'd2, 4'hF, 32'h0, 8'd2);
        get_rsp("rd_full", AccessAckData, 1'b0, 32'hDEAD_BEEF, 8'd2, 2'd2);

        // Partial write, lanes 0 and 2
        send(0, PutPartialData, 32'h10, 2'd2, 4'b0101, 32'h1122_3344, 8'd3);
        get_rsp("wr_part", AccessAck, 1'b0, 32'h0, 8'd3, 2'd2);
        send(0, Get, 32'h10, 2'd2, 4'h0, 32'h0, 8'd4);
        get_rsp("rd_part", AccessAckData, 1'b0, 32'hDE22_BE44, 8'd4, 2'd2);

        // Read-after-write in consecutive cycles
        send(0, PutFullData, 32'h20, 2'd2, 4'hF, 32'hCAFE_F00D, 8'd5);
        send(0, Get, 32'h20, 2'd2, 4'hF, 32'h0, 8'd6);
        get_rsp("raw_wr", AccessAck, 1'b0, 32'h0, 8'd5, 2'd2);
        get_rsp("raw_rd", AccessAckData, 1'b0, 32'hCAFE_F00D, 8'd6, 2'd2);

        // Last word of the array
        send(0, PutFullData, 32'h3C, 2'd2, 4'hF, 32'h0BAD_F00D, 8'd7);
        send(0, Get, 32'h3C, 2'd1, 4'hF, 32'h0, 8'd8);
        get_rsp("last_wr", AccessAck, 1'b0, 32'h0, 8'd7, 2'd2);
        get_rsp("last_rd", AccessAckData, 1'b0, 32'h0BAD_F00D, 8'd8, 2'd1);

        // Backpressure: four accepted, then a_ready drops
        h2d[0].d_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(0, Get, (i % 2 == 0) ? 32'h10 : 32'h20, 2'd2, 4'hF, 32'h0, 8'(10 + i));
        end
        h2d[0].a_valid   = 1'b1;
        h2d[0].a_source  = 8'd14;
        h2d[0].a_address = 32'h10;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("full_a_ready", 32'(d2h[0].a_ready), 32'd0);
            chk("stall_d_source", 32'(d2h[0].d_source), 32'd10);
            chk("stall_d_data", d2h[0].d_data, 32'hDE22_BE44);
            @(negedge clk);
        end
        #1;
        chk("stall_zero_fields", {d2h[0].d_param, d2h[0].d_sink, d2h[0].d_user}, 32'd0);
        @(negedge clk);
        h2d[0].a_valid = 1'b0;
        h2d[0].d_ready = 1'b1;
        #1;
        chk("pre_hs_a_ready", 32'(d2h[0].a_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("post_hs_a_ready", 32'(d2h[0].a_ready), 32'd1);
        @(negedge clk);
        send(0, Get, 32'h10, 2'd2, 4'hF, 32'h0, 8'd14);
        send(0, Get, 32'h20, 2'd2, 4'hF, 32'h0, 8'd15);
        for (int i = 0; i < 6; i++) begin
            get_rsp("bp_rd", AccessAckData, 1'b0,
                    (i % 2 == 0) ? 32'hDE22_BE44 : 32'hCAFE_F00D, 8'(10 + i), 2'd2);
        end

        // Error responses
        send(0, Get, 32'h40, 2'd2, 4'hF, 32'h0, 8'd20);
        get_rsp("err_range", AccessAckData, 1'b1, 32'h0, 8'd20, 2'd2);
        send(0, 3'd7, 32'h0, 2'd2, 4'hF, 32'h0, 8'd21);
        get_rsp("err_opcode", AccessAck, 1'b1, 32'h0, 8'd21, 2'd2);
        send(0, Get, 32'h10, 2'd3, 4'hF, 32'h0, 8'd22);
        get_rsp("err_size_rd", AccessAckData, 1'b1, 32'h0, 8'd22, 2'd3);
        send(0, PutFullData, 32'h10, 2'd3, 4'hF, 32'h5555_5555, 8'd23);
        get_rsp("err_size_wr", AccessAck, 1'b1, 32'h0, 8'd23, 2'd3);
        send(0, Get, 32'h10, 2'd2, 4'hF, 32'h0, 8'd24);
        get_rsp("err_no_write", AccessAckData, 1'b0, 32'hDE22_BE44, 8'd24, 2'd2);

        // Reset with three responses pending
        h2d[0].d_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(0, Get, 32'h20, 2'd2, 4'hF, 32'h0, 8'(30 + i));
        end
        #1;
        chk("pend_d_valid", 32'(d2h[0].d_valid), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_d_valid", 32'(d2h[0].d_valid), 32'd0);
        chk("async_rst_d_data", d2h[0].d_data, 32'h0);
        chk("async_rst_a_ready", 32'(d2h[0].a_ready), 32'd0);
        rq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        h2d[0].d_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rel_a_ready", 32'(d2h[0].a_ready), 32'd1);
        repeat (5) @(negedge clk);
        #2;
        chk("no_stale_rsp", 32'(rq.size()), 32'd0);
        chk("no_stale_d_valid", 32'(d2h[0].d_valid), 32'd0);
        @(negedge clk);

        // ErrOnWrite instance
        send(1, PutFullData, 32'h0, 2'd2, 4'hF, 32'h1111_1111, 8'd40);
        get_rsp("ew_wr", AccessAck, 1'b1, 32'h0, 8'd40, 2'd2);
        send(1, Get, 32'h0, 2'd2, 4'hF, 32'h0, 8'd41);
        get_rsp("ew_rd", AccessAckData, 1'b0, 32'h5A5A_1234, 8'd41, 2'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tlul_sram_ctrl.md
# tlul_sram_ctrl

Parametrised TL-UL device that fronts a single-port, byte-maskable, word-addressed SRAM and sits on a crossbar device port in place of a fixed-size memory wrapper. It is the next generation of the data-memory wrapper. Over that wrapper it adds:
- configurable depth;
- per-byte write enables taken directly from `a_mask`;
- write acknowledgements;
- protocol, range and permission error responses;
- a bounded-outstanding response queue that tolerates `d_ready` backpressure without loss.

## Interface

Parameters:
- `Depth`, 4096: number of 32-bit words; power of two, at least 16.
- `Outstanding`, 4: maximum number of accepted requests whose response has not yet been taken; at least 2.
- `ErrOnWrite`, 0: when 1, every Put request is answered with an error and the SRAM is not written.
- `ErrOnRead`, 0: when 1, every Get request is answered with an error and the SRAM is not read.

Ports:
- `clk_i`, input, 1: single clock; all state changes on its rising edge.
- `rst_i`, input, 1: reset, asynchronous assert, active-high.
- `tl_i`, input, `tlul_pkg::tl_h2d_t`: A channel plus `d_ready`.
- `tl_o`, output, `tlul_pkg::tl_d2h_t`: D channel plus `a_ready`.

## Operation

- A request is accepted in a cycle where `a_valid` and `a_ready` are both 1.
- `a_ready` is 1 when all of the following hold:
  - `rst_i` is 0;
  - `inflight < Outstanding`, where `inflight` counts stage-register occupancy plus queue occupancy.
- `a_ready` is a function of registered state only. It has no combinational path from `d_ready`.
- The word index is `a_address[$clog2(Depth)+1:2]`. Bits `[1:0]` are ignored for SRAM indexing.
- An accepted request is an error when any of the following holds:
  - opcode is not Get (4), PutFullData (0) or PutPartialData (1);
  - `a_size > 2`;
  - `a_address >= Depth*4`;
  - `ErrOnWrite` is set and the request is a Put;
  - `ErrOnRead` is set and the request is a Get.
- Error requests never access the SRAM.
- A legal Put writes byte lane b (b = 0..3) iff `a_mask[b]`. Lanes with a 0 mask bit keep their old contents.
- A legal Get reads the full 32-bit word regardless of `a_mask`.
- Every accepted request produces exactly one response, in acceptance order:
  - `d_opcode`: AccessAckData (1) for Get, AccessAck (0) otherwise, including error responses to bad opcodes.
  - `d_size` and `d_source` echo the request.
  - `d_param`, `d_sink` and `d_user` are 0.
  - `d_error` is 1 for error requests.
  - `d_data` is the read word for legal Gets and 0 for everything else.
- Response pipeline:
  - Stage register S captures request metadata at acceptance. SRAM read data is valid in the following cycle.
  - The response queue is a fall-through FIFO of `Outstanding-1` entries.
  - When the queue is empty and S is valid, the D channel is driven directly from S plus SRAM read data.
  - Otherwise S pushes into the queue and the D channel is driven from the queue head.
- `inflight` update per cycle:
  - +1 on A-channel acceptance;
  - -1 on D-channel handshake (`d_valid && d_ready`);
  - unchanged when both occur in the same cycle.
- SRAM contents are not reset.

## Timing

- Reset values while `rst_i` is high: `a_ready=0`, `d_valid=0`, all D fields 0, `inflight=0`, queue empty, S invalid.
- Reset asserted mid-operation discards all in-flight responses immediately (asynchronously).
- First acceptance is possible in the first cycle after `rst_i` is sampled low.
- A request accepted in cycle N:
  - a legal Put updates the SRAM at the N/N+1 edge;
  - the response can appear with `d_valid=1` in cycle N+1 at the earliest.
- Back-to-back throughput is one request per cycle while `d_ready` stays 1.
- While `d_valid` is 1 and `d_ready` is 0, all D fields hold stable.
- Read-after-write: a Get accepted in cycle N+1 to the same word as a Put accepted in cycle N returns the new data.
- Full condition: with `d_ready=0`, exactly `Outstanding` requests are accepted, then `a_ready` drops.
- `a_ready` returns to 1 in the cycle after the first D-channel handshake.

## Structure

- Types and constants live in `tlul_pkg`, used unchanged: opcodes, `tl_h2d_t`, `tl_d2h_t`.
- A small `tlul_sram_ctrl_pkg` holds:
  - the response record type `rsp_t` (opcode, size, source, error, is_read);
  - the function that decides whether a request is an error.
- One sub-module, `tlul_rsp_fifo`:
  - parametrised fall-through FIFO;
  - parameters: entry type and depth;
  - ports: push/pop, full/empty and count.
- The SRAM is a behavioural `logic [31:0] mem [Depth]` with per-byte write enables, held inside the top module.

## Test plan

- Reset then a single write and read: PutFullData to 0x10 with data 0xDEADBEEF and mask 0xF, then Get 0x10.
  - Write response: AccessAck with `d_error=0`.
  - Read response: AccessAckData with `d_data=0xDEADBEEF`.
- Partial write: after the above, PutPartialData to 0x10 with mask 0b0101 and data 0x11223344, then Get.
  - Required read data: 0xDE22BE44.
- Backpressure with `Outstanding=4`: hold `d_ready=0` and issue 6 Gets back-to-back.
  - Exactly 4 Gets are accepted, then `a_ready=0`.
  - Release `d_ready`: 4 responses in order with correct `d_source`, then the remaining 2 are accepted.
- Error cases, each with its required response:
  - Get at `Depth*4`: `d_error=1`, `d_data=0`.
  - Opcode 7: AccessAck with `d_error=1`.
  - `a_size=3`: error response.
  - With `ErrOnWrite=1`, a PutFullData to 0x0 returns `d_error=1`, and a following Get 0x0 returns the old data.
- Read-after-write in consecutive cycles: Put 0xCAFEF00D to 0x20, then Get 0x20 in the next cycle.
  - Required read data: 0xCAFEF00D.
- Reset asserted with 3 responses pending:
  - `d_valid` falls immediately;
  - after release, no stale response appears;
  - `a_ready=1` on the first cycle after `rst_i` is sampled low.
